// File: rtl/vote_pkg.sv
// Shared types for the ballot counter: FSM state encoding and the press classifier.
package vote_pkg;

    localparam int MAX_CAND = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        HOLD  = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } vote_state_t;

    typedef enum logic [1:0] {
        PRESS_NONE  = 2'd0,
        PRESS_ONE   = 2'd1,
        PRESS_MULTI = 2'd2
    } press_t;

    // v & (v-1) clears the lowest set bit; anything left means two or more buttons.
    function automatic press_t classify_press(input logic [MAX_CAND-1:0] v);
        press_t kind;
        if (v == {MAX_CAND{1'b0}}) begin
            kind = PRESS_NONE;
        end else if ((v & (v - {{(MAX_CAND-1){1'b0}}, 1'b1})) != {MAX_CAND{1'b0}}) begin
            kind = PRESS_MULTI;
        end else begin
            kind = PRESS_ONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// Saturating vote counter with a sticky flag that sets on the increment reaching all-ones.
module vote_counter_sat import vote_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             saturated
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic             sat_r;
    logic [CNT_W-1:0] count_inc_s;

    // Incremented value, only used when the counter is below its ceiling.
    always_comb begin
        count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Counter and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_inc_s;
            if (count_inc_s == CNT_MAX) begin
                sat_r <= 1'b1;
            end
        end
    end

    assign count     = count_r;
    assign saturated = sat_r;

endmodule

// File: rtl/vote_tally.sv
// Ballot FSM (arm / press / release), per-candidate saturating counters and a
// one-candidate-per-cycle winner scan for the result display.
module vote_tally import vote_pkg::*; #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      ballot_open,
    input  logic [NUM_CAND-1:0]       vote_valid,
    output logic                      armed,
    output logic                      vote_accepted,
    output logic                      vote_rejected,
    output logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [NUM_CAND-1:0]       saturated,
    output logic [IDX_W-1:0]          winner_idx,
    output logic                      tie,
    output logic                      winner_valid
);

    localparam int SCAN_W = IDX_W + 1;
    localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(NUM_CAND);

    vote_state_t         state_r, next_state_s;
    press_t              press_s;
    logic                hold_acc_r;
    logic [NUM_CAND-1:0] inc_s;
    logic                accept_s, reject_s, scan_start_s;
    logic [SCAN_W-1:0]   scan_idx_r;
    logic [CNT_W-1:0]    max_r, cur_cnt_s;
    logic [IDX_W-1:0]    winner_idx_r;
    logic                tie_r, winner_valid_r, armed_r, accepted_r, rejected_r;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
        vote_counter_sat #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_s[g]),
            .count     (counts[g*CNT_W +: CNT_W]),
            .saturated (saturated[g])
        );
    end

    // Next-state decode; mode has priority over a press so a ballot is dropped on entering SCAN.
    always_comb begin
        next_state_s = state_r;
        inc_s        = {NUM_CAND{1'b0}};
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        press_s      = classify_press(MAX_CAND'(vote_valid));
        case (state_r)
            IDLE: begin
                if (mode) begin
                    next_state_s = SCAN;
                end else if (ballot_open) begin
                    next_state_s = ARMED;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARMED: begin
                if (mode) begin
                    next_state_s = SCAN;
                end else begin
                    case (press_s)
                        PRESS_ONE: begin
                            inc_s        = vote_valid;
                            accept_s     = 1'b1;
                            next_state_s = HOLD;
                        end
                        PRESS_MULTI: begin
                            reject_s     = 1'b1;
                            next_state_s = HOLD;
                        end
                        default: next_state_s = ARMED;
                    endcase
                end
            end
            HOLD: begin
                if (vote_valid == {NUM_CAND{1'b0}}) begin
                    next_state_s = hold_acc_r ? IDLE : ARMED;
                end else begin
                    next_state_s = HOLD;
                end
            end
            SCAN: begin
                if (scan_idx_r == SCAN_END) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SCAN;
                end
            end
            DONE: begin
                if (!mode) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
        scan_start_s = (next_state_s == SCAN) && (state_r != SCAN);
    end

    // Count of the candidate currently under the scan pointer.
    always_comb begin
        cur_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CAND; i++) begin
            cur_cnt_s = (scan_idx_r == SCAN_W'(i)) ? counts[i*CNT_W +: CNT_W] : cur_cnt_s;
        end
    end

    // State, registered status outputs and the running-maximum comparator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            hold_acc_r     <= 1'b0;
            armed_r        <= 1'b0;
            accepted_r     <= 1'b0;
            rejected_r     <= 1'b0;
            winner_valid_r <= 1'b0;
            scan_idx_r     <= {SCAN_W{1'b0}};
            max_r          <= {CNT_W{1'b0}};
            winner_idx_r   <= {IDX_W{1'b0}};
            tie_r          <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            armed_r        <= (next_state_s == ARMED);
            accepted_r     <= accept_s;
            rejected_r     <= reject_s;
            winner_valid_r <= (next_state_s == DONE);
            if (accept_s) begin
                hold_acc_r <= 1'b1;
            end else if (reject_s) begin
                hold_acc_r <= 1'b0;
            end
            // Max starts at zero, so an all-zero tally ends as index 0 with tie set.
            if (scan_start_s) begin
                scan_idx_r   <= {SCAN_W{1'b0}};
                max_r        <= {CNT_W{1'b0}};
                winner_idx_r <= {IDX_W{1'b0}};
                tie_r        <= 1'b0;
            end else if ((state_r == SCAN) && (scan_idx_r != SCAN_END)) begin
                scan_idx_r <= scan_idx_r + {{(SCAN_W-1){1'b0}}, 1'b1};
                if (cur_cnt_s > max_r) begin
                    max_r        <= cur_cnt_s;
                    winner_idx_r <= scan_idx_r[IDX_W-1:0];
                    tie_r        <= 1'b0;
                end else if (cur_cnt_s == max_r) begin
                    tie_r <= 1'b1;
                end
            end
        end
    end

    assign armed         = armed_r;
    assign vote_accepted = accepted_r;
    assign vote_rejected = rejected_r;
    assign winner_idx    = winner_idx_r;
    assign tie           = tie_r;
    assign winner_valid  = winner_valid_r;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: vector table, directed corner sequences,
// then randomized traffic against a behavioural ballot model.
module tb_vote_tally;

    localparam int NC = 4;
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic          ballot_open = 1'b0;
    logic [NC-1:0] vote_valid = '0;
    logic          armed, vote_accepted, vote_rejected, tie, winner_valid;
    logic [NC*CW-1:0] counts;
    logic [NC-1:0] saturated;
    logic [1:0]    winner_idx;

    int checks = 0;
    int errors = 0;

    vote_tally #(.NUM_CAND(NC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .ballot_open(ballot_open),
        .vote_valid(vote_valid), .armed(armed), .vote_accepted(vote_accepted),
        .vote_rejected(vote_rejected), .counts(counts), .saturated(saturated),
        .winner_idx(winner_idx), .tie(tie), .winner_valid(winner_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*CW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {c3[CW-1:0], c2[CW-1:0], c1[CW-1:0], c0[CW-1:0]};
    endfunction

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; ballot_open = 1'b0; vote_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One complete ballot: arm, press for one cycle, release. Returns accept/reject seen.
    task automatic cast(input logic [NC-1:0] vv, output logic acc, output logic rej);
        ballot_open = 1'b1;
        step();
        ballot_open = 1'b0;
        vote_valid  = vv;
        step();
        acc = vote_accepted;
        rej = vote_rejected;
        vote_valid = '0;
        step();
    endtask

    // mode sampled at edge N; result must appear exactly after edge N+NC+1.
    task automatic do_scan(input string name, input logic [1:0] exp_idx, input logic exp_tie);
        mode = 1'b1;
        step();
        for (int i = 0; i < NC; i++) step();
        check({name, "_wv_early"}, winner_valid, 1'b0);
        step();
        check({name, "_wv"}, winner_valid, 1'b1);
        check({name, "_idx"}, winner_idx, exp_idx);
        check({name, "_tie"}, tie, exp_tie);
        mode = 1'b0;
        step();
        check({name, "_wv_clear"}, winner_valid, 1'b0);
    endtask

    typedef struct {
        logic          md;
        logic          bo;
        logic [NC-1:0] vv;
        logic          e_armed;
        logic          e_acc;
        logic          e_rej;
        logic [NC*CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic md, input logic bo, input logic [NC-1:0] vv,
                                input logic ea, input logic eacc, input logic erej,
                                input logic [NC*CW-1:0] ec);
        vec_t v;
        v.md = md; v.bo = bo; v.vv = vv;
        v.e_armed = ea; v.e_acc = eacc; v.e_rej = erej; v.e_cnt = ec;
        return v;
    endfunction

    // Behavioural model state
    localparam int P_IDLE = 0, P_ARMED = 1, P_HOLD = 2, P_SCAN = 3, P_DONE = 4;
    int   m_phase, m_left;
    int   m_cnt[NC];
    bit   m_retry, m_acc, m_rej;

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_retry = 1'b0; m_acc = 1'b0; m_rej = 1'b0;
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic md, input logic bo, input logic [NC-1:0] vv);
        int pop;
        pop = $countones(vv);
        m_acc = 1'b0;
        m_rej = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (md) begin m_phase = P_SCAN; m_left = NC + 1; end
                else if (bo) m_phase = P_ARMED;
            end
            P_ARMED: begin
                if (md) begin
                    m_phase = P_SCAN; m_left = NC + 1;
                end else if (pop == 1) begin
                    for (int i = 0; i < NC; i++)
                        if (vv[i] && m_cnt[i] < CMAX) m_cnt[i]++;
                    m_acc = 1'b1; m_retry = 1'b0; m_phase = P_HOLD;
                end else if (pop > 1) begin
                    m_rej = 1'b1; m_retry = 1'b1; m_phase = P_HOLD;
                end
            end
            P_HOLD: if (pop == 0) m_phase = m_retry ? P_ARMED : P_IDLE;
            P_SCAN: begin
                m_left--;
                if (m_left == 0) m_phase = P_DONE;
            end
            default: if (!md) m_phase = P_IDLE;
        endcase
    endtask

    initial begin
        logic acc, rej;
        int   acc_seen;
        logic [NC*CW-1:0] snap;
        logic [NC-1:0] rvv;
        logic [NC*CW-1:0] e_cnt;
        logic [NC-1:0] e_sat;
        int   mx, first, nmax, r;

        // Reset state
        do_reset();
        check("rst_armed", armed, 1'b0);
        check("rst_acc", vote_accepted, 1'b0);
        check("rst_rej", vote_rejected, 1'b0);
        check("rst_counts", counts, '0);
        check("rst_sat", saturated, '0);
        check("rst_wv", winner_valid, 1'b0);
        check("rst_idx", winner_idx, 2'd0);
        check("rst_tie", tie, 1'b0);

        // Basic vote, ignored ballot_open while held, multi-hot reject and retry
        vecs[0]  = mk(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0));
        vecs[1]  = mk(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, pk(0, 0, 1, 0));
        vecs[2]  = mk(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[3]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[4]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[5]  = mk(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[6]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[7]  = mk(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[8]  = mk(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, pk(0, 0, 1, 0));
        vecs[9]  = mk(1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[10] = mk(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0));
        vecs[11] = mk(1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, pk(1, 0, 1, 0));
        vecs[12] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, pk(1, 0, 1, 0));
        for (int i = 0; i < 13; i++) begin
            mode = vecs[i].md; ballot_open = vecs[i].bo; vote_valid = vecs[i].vv;
            step();
            check($sformatf("vec%0d_armed", i), armed, vecs[i].e_armed);
            check($sformatf("vec%0d_acc", i), vote_accepted, vecs[i].e_acc);
            check($sformatf("vec%0d_rej", i), vote_rejected, vecs[i].e_rej);
            check($sformatf("vec%0d_counts", i), counts, vecs[i].e_cnt);
        end
        ballot_open = 1'b0; vote_valid = '0;

        // All-zero tally scans to index 0 with tie
        do_reset();
        do_scan("scan_zero", 2'd0, 1'b1);

        // Saturation at CNT_W=3: nine ballots, all accepted, counter pinned at 7
        do_reset();
        acc_seen = 0;
        for (int i = 0; i < 9; i++) begin
            cast(4'b0010, acc, rej);
            acc_seen += int'(acc);
        end
        check("sat_accepts", acc_seen, 9);
        check("sat_counts", counts, pk(0, 7, 0, 0));
        check("sat_flag", saturated, 4'b0010);

        // Result scan on {3,5,5,1}, then {3,6,5,1}
        do_reset();
        for (int i = 0; i < 3; i++) cast(4'b0001, acc, rej);
        for (int i = 0; i < 5; i++) cast(4'b0010, acc, rej);
        for (int i = 0; i < 5; i++) cast(4'b0100, acc, rej);
        cast(4'b1000, acc, rej);
        check("scan_setup", counts, pk(3, 5, 5, 1));
        do_scan("scan_tie", 2'd1, 1'b1);
        cast(4'b0010, acc, rej);
        do_scan("scan_win", 2'd1, 1'b0);

        // mode raised while a button is held: no scan until release, then blocked in DONE
        do_reset();
        ballot_open = 1'b1;
        step();
        ballot_open = 1'b0; vote_valid = 4'b1000;
        step();
        check("hold_acc", vote_accepted, 1'b1);
        mode = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("hold_no_scan", winner_valid, 1'b0);
        check("hold_armed", armed, 1'b0);
        vote_valid = 4'b0000;
        step();
        for (int i = 0; i < NC + 1; i++) step();
        check("hold_wv_early", winner_valid, 1'b0);
        step();
        check("hold_wv", winner_valid, 1'b1);
        check("hold_idx", winner_idx, 2'd3);
        check("hold_tie", tie, 1'b0);
        snap = counts;
        ballot_open = 1'b1; vote_valid = 4'b0001;
        step();
        ballot_open = 1'b0;
        step();
        check("done_no_acc", vote_accepted, 1'b0);
        check("done_armed", armed, 1'b0);
        check("done_counts", counts, snap);
        check("done_wv_hold", winner_valid, 1'b1);
        vote_valid = '0; mode = 1'b0;
        step();
        check("done_exit", winner_valid, 1'b0);

        // Reset in scan cycle 2
        do_reset();
        cast(4'b0100, acc, rej);
        mode = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check("rscan_counts", counts, '0);
        check("rscan_wv", winner_valid, 1'b0);
        check("rscan_tie", tie, 1'b0);
        reset = 1'b0; mode = 1'b0; ballot_open = 1'b1;
        step();
        check("rscan_idle", armed, 1'b1);
        ballot_open = 1'b0;

        // Randomized traffic against the behavioural model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            ballot_open = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 99);
            if (r < 50) rvv = 4'b0000;
            else if (r < 85) rvv = 4'b0001 << $urandom_range(0, 3);
            else rvv = 4'($urandom_range(1, 15));
            vote_valid = rvv;
            reset = ($urandom_range(0, 499) == 0);
            step();
            if (reset) model_reset();
            else model_step(mode, ballot_open, rvv);
            e_cnt = pk(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
            for (int i = 0; i < NC; i++) e_sat[i] = (m_cnt[i] == CMAX);
            check("rnd_armed", armed, (m_phase == P_ARMED));
            check("rnd_acc", vote_accepted, m_acc);
            check("rnd_rej", vote_rejected, m_rej);
            check("rnd_counts", counts, e_cnt);
            check("rnd_sat", saturated, e_sat);
            check("rnd_wv", winner_valid, (m_phase == P_DONE));
            if (m_phase == P_DONE) begin
                mx = -1; first = 0; nmax = 0;
                for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) begin mx = m_cnt[i]; first = i; end
                for (int i = 0; i < NC; i++) if (m_cnt[i] == mx) nmax++;
                check("rnd_idx", winner_idx, first[1:0]);
                check("rnd_tie", tie, (nmax > 1));
            end
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
